egg_timer_ctrl: RTL and testbench



---
 rtl/egg_timer_ctrl.sv | 170 +++++++++++++++++
 tb/tb_egg_timer_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/egg_timer_ctrl.sv
// Egg-timer controller: key-driven mode FSM, mm:ss countdown with 1 s prescaler,
// pause/resume and a flashing alarm that auto-acknowledges and reloads the last setting.
module egg_timer_ctrl #(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned MAX_MIN       = 99,
  parameter int unsigned MIN_W         = $clog2(MAX_MIN + 1),
  parameter int unsigned SET_W         = 8,
  parameter int unsigned FLASH_DIV     = 12500000,
  parameter int unsigned ALARM_TOGGLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       key,
  input  logic [SET_W-1:0] set_val,
  output logic [2:0]       state,
  output logic [MIN_W-1:0] min_out,
  output logic [5:0]       sec_out,
  output logic             alarm,
  output logic             flash,
  output logic             done
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned FLASH_W = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam int unsigned TOG_W   = (ALARM_TOGGLES > 0) ? $clog2(ALARM_TOGGLES + 1) : 1;

  localparam logic [2:0] StSetSec   = 3'd0;
  localparam logic [2:0] StSetMin   = 3'd1;
  localparam logic [2:0] StTimer    = 3'd2;
  localparam logic [2:0] StReady    = 3'd3;
  localparam logic [2:0] StReset    = 3'd4;
  localparam logic [2:0] StFlashOn  = 3'd5;
  localparam logic [2:0] StFlashOff = 3'd6;
  localparam logic [2:0] StPause    = 3'd7;

  logic [2:0]         state_q, state_d;
  logic [MIN_W-1:0]   min_q, min_d, load_min_q, load_min_d, dec_min;
  logic [5:0]         sec_q, sec_d, load_sec_q, load_sec_d, dec_sec;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic [TOG_W-1:0]   tog_q, tog_d;
  logic [1:0]         key_q;
  logic               done_q, done_d;
  logic               press1, press2, tick;

  // History holds key[2:1] only; key[0] is level-sensitive.
  assign press1 = key[1] & ~key_q[0];
  assign press2 = key[2] & ~key_q[1];
  assign tick   = (presc_q == PRESC_W'(TICK_DIV - 1));

  always_comb begin
    if (sec_q == 6'd0) begin
      dec_sec = 6'd59;
      dec_min = min_q - MIN_W'(1);
    end else begin
      dec_sec = sec_q - 6'd1;
      dec_min = min_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    load_min_d  = load_min_q;
    load_sec_d  = load_sec_q;
    presc_d     = presc_q;
    flash_cnt_d = flash_cnt_q;
    tog_d       = tog_q;
    done_d      = 1'b0;
    if (key[0]) begin
      state_d     = StReset;
      min_d       = '0;
      sec_d       = '0;
      load_min_d  = '0;
      load_sec_d  = '0;
      presc_d     = '0;
      flash_cnt_d = '0;
      tog_d       = '0;
    end else begin
      case (state_q)
        StReset: state_d = StSetSec;
        StSetSec: if (press1) begin
          sec_d      = (32'(set_val) > 32'd59) ? 6'd59 : 6'(set_val);
          load_sec_d = sec_d;
          state_d    = StSetMin;
        end
        StSetMin: if (press1) begin
          min_d      = (32'(set_val) > MAX_MIN) ? MIN_W'(MAX_MIN) : MIN_W'(set_val);
          load_min_d = min_d;
          state_d    = StReady;
        end
        StReady: if (press2 && (min_q != '0 || sec_q != '0)) begin
          presc_d = '0;
          state_d = StTimer;
        end
        StTimer: begin
          presc_d = tick ? '0 : presc_q + PRESC_W'(1);
          if (press2) state_d = StPause;
          if (tick) begin
            min_d = dec_min;
            sec_d = dec_sec;
            // Expiry overrides a pause pressed on the same cycle.
            if (dec_min == '0 && dec_sec == 6'd0) begin
              done_d      = 1'b1;
              flash_cnt_d = '0;
              tog_d       = '0;
              state_d     = StFlashOn;
            end
          end
        end
        StPause: if (press2) state_d = StTimer;
        StFlashOn, StFlashOff: begin
          if (press2) begin
            min_d   = load_min_q;
            sec_d   = load_sec_q;
            state_d = StReady;
          end else if (flash_cnt_q == FLASH_W'(FLASH_DIV - 1)) begin
            flash_cnt_d = '0;
            tog_d       = tog_q + TOG_W'(1);
            if (ALARM_TOGGLES != 0 && 32'(tog_q) + 32'd1 == ALARM_TOGGLES) begin
              min_d   = load_min_q;
              sec_d   = load_sec_q;
              state_d = StReady;
            end else begin
              state_d = (state_q == StFlashOn) ? StFlashOff : StFlashOn;
            end
          end else begin
            flash_cnt_d = flash_cnt_q + FLASH_W'(1);
          end
        end
        default: state_d = StReset;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StReset;
      min_q       <= '0;
      sec_q       <= '0;
      load_min_q  <= '0;
      load_sec_q  <= '0;
      presc_q     <= '0;
      flash_cnt_q <= '0;
      tog_q       <= '0;
      key_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      load_min_q  <= load_min_d;
      load_sec_q  <= load_sec_d;
      presc_q     <= presc_d;
      flash_cnt_q <= flash_cnt_d;
      tog_q       <= tog_d;
      key_q       <= key[2:1];
      done_q      <= done_d;
    end
  end

  assign state   = state_q;
  assign min_out = min_q;
  assign sec_out = sec_q;
  assign alarm   = (state_q == StFlashOn) || (state_q == StFlashOff);
  assign flash   = (state_q == StFlashOn);
  assign done    = done_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl: vector table for set/hold/abort, then
// hand-written sequences for countdown, pause, expiry, alarm, zero and reset corners.
module tb_egg_timer_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] key;
  logic [7:0] set_val;
  logic [2:0] state;
  logic [6:0] min_out;
  logic [5:0] sec_out;
  logic       alarm, flash, done;

  int checks = 0;
  int failures = 0;

  egg_timer_ctrl #(
    .TICK_DIV(4), .MAX_MIN(99), .SET_W(8), .FLASH_DIV(2), .ALARM_TOGGLES(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .key(key), .set_val(set_val), .state(state),
    .min_out(min_out), .sec_out(sec_out), .alarm(alarm), .flash(flash), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [6:0] mn;
    logic [5:0] sc;
    logic       al;
    logic       fl;
    logic       dn;
  } exp_t;

  typedef struct {
    logic [2:0] k;
    logic [7:0] v;
    logic [2:0] st;
    int         mn;
    int         sc;
    logic       dn;
  } vec_t;

  exp_t  eq[$];
  string nq[$];
  vec_t  vt[16];

  task automatic push_exp(input string nm, input logic [2:0] st, input int mn, input int sc,
                          input logic dn);
    exp_t e;
    e.st = st;
    e.mn = 7'(mn);
    e.sc = 6'(sc);
    e.al = (st == 3'd5) || (st == 3'd6);
    e.fl = (st == 3'd5);
    e.dn = dn;
    eq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic pop_cmp();
    exp_t  e;
    string nm;
    checks++;
    if (eq.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expectation queued");
      return;
    end
    e  = eq.pop_front();
    nm = nq.pop_front();
    if ({state, min_out, sec_out, alarm, flash, done} !== {e.st, e.mn, e.sc, e.al, e.fl, e.dn})
    begin
      failures++;
      $display("FAIL %s: got st=%0d mm=%0d ss=%0d al=%b fl=%b dn=%b want st=%0d mm=%0d ss=%0d al=%b fl=%b dn=%b",
               nm, state, min_out, sec_out, alarm, flash, done,
               e.st, e.mn, e.sc, e.al, e.fl, e.dn);
    end
  endtask

  task automatic step(input logic [2:0] k, input logic [7:0] v);
    key = k;
    set_val = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step_exp(input string nm, input logic [2:0] k, input logic [7:0] v,
                          input logic [2:0] st, input int mn, input int sc, input logic dn);
    key = k;
    set_val = v;
    push_exp(nm, st, mn, sc, dn);
    @(posedge clk);
    #1;
    pop_cmp();
  endtask

  task automatic chk_now(input string nm, input logic [2:0] st, input int mn, input int sc,
                         input logic dn);
    push_exp(nm, st, mn, sc, dn);
    pop_cmp();
  endtask

  initial begin
    int fs[8];
    fs = '{5, 6, 6, 5, 5, 6, 6, 3};

    // Reset/set/held-key/abort vectors applied one per clock.
    vt[0]  = '{3'b000, 8'd0,  3'd0, 0, 0,  1'b0};
    vt[1]  = '{3'b010, 8'd75, 3'd1, 0, 59, 1'b0};
    for (int i = 2; i <= 10; i++) vt[i] = '{3'b010, 8'd2, 3'd1, 0, 59, 1'b0};
    vt[11] = '{3'b000, 8'd2,  3'd1, 0, 59, 1'b0};
    vt[12] = '{3'b010, 8'd2,  3'd3, 2, 59, 1'b0};
    vt[13] = '{3'b000, 8'd2,  3'd3, 2, 59, 1'b0};
    vt[14] = '{3'b001, 8'd0,  3'd4, 0, 0,  1'b0};
    vt[15] = '{3'b000, 8'd0,  3'd0, 0, 0,  1'b0};

    reset_n = 1'b0;
    key = 3'b000;
    set_val = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_now("reset_state", 3'd4, 0, 0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      step_exp($sformatf("vec%0d", i), vt[i].k, vt[i].v, vt[i].st, vt[i].mn, vt[i].sc, vt[i].dn);
    end

    // Countdown 01:00 -> 00:00 with minute borrow, then auto-acknowledged alarm.
    step_exp("set_sec0", 3'b010, 8'd0, 3'd1, 0, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("set_min1", 3'b010, 8'd1, 3'd3, 1, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("start_0100", 3'b100, 8'd0, 3'd2, 1, 0, 1'b0);
    repeat (3) step(3'b000, 8'd0);
    step_exp("first_tick", 3'b000, 8'd0, 3'd2, 0, 59, 1'b0);
    repeat (231) step(3'b000, 8'd0);
    step_exp("at_0001", 3'b000, 8'd0, 3'd2, 0, 1, 1'b0);
    repeat (3) step(3'b000, 8'd0);
    step_exp("expire", 3'b000, 8'd0, 3'd5, 0, 0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step_exp($sformatf("flash%0d", i), 3'b000, 8'd0, 3'(fs[i]), (i == 7) ? 1 : 0, 0, 1'b0);
    end

    // Pause preserves the prescaler; expiry beats a simultaneous pause press.
    step_exp("abort1", 3'b001, 8'd0, 3'd4, 0, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("set_sec3", 3'b010, 8'd3, 3'd1, 0, 3, 1'b0);
    step(3'b000, 8'd0);
    step_exp("set_min0", 3'b010, 8'd0, 3'd3, 0, 3, 1'b0);
    step(3'b000, 8'd0);
    step_exp("start_0003", 3'b100, 8'd0, 3'd2, 0, 3, 1'b0);
    repeat (3) step(3'b000, 8'd0);
    step_exp("tick_0002", 3'b000, 8'd0, 3'd2, 0, 2, 1'b0);
    step(3'b000, 8'd0);
    step_exp("pause", 3'b100, 8'd0, 3'd7, 0, 2, 1'b0);
    repeat (49) step(3'b000, 8'd0);
    step_exp("pause_hold", 3'b000, 8'd0, 3'd7, 0, 2, 1'b0);
    step_exp("resume", 3'b100, 8'd0, 3'd2, 0, 2, 1'b0);
    step_exp("resume_p1", 3'b000, 8'd0, 3'd2, 0, 2, 1'b0);
    step_exp("resume_tick", 3'b000, 8'd0, 3'd2, 0, 1, 1'b0);
    repeat (2) step(3'b000, 8'd0);
    step_exp("pre_same", 3'b000, 8'd0, 3'd2, 0, 1, 1'b0);
    step_exp("tick_and_pause", 3'b100, 8'd0, 3'd5, 0, 0, 1'b1);
    step_exp("flash_hold", 3'b000, 8'd0, 3'd5, 0, 0, 1'b0);
    step_exp("flash_off", 3'b000, 8'd0, 3'd6, 0, 0, 1'b0);
    step_exp("ack_in_off", 3'b100, 8'd0, 3'd3, 0, 3, 1'b0);
    step(3'b000, 8'd0);

    // 00:00 cannot start.
    step_exp("abort2", 3'b001, 8'd0, 3'd4, 0, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("zero_sec", 3'b010, 8'd0, 3'd1, 0, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("zero_min", 3'b010, 8'd0, 3'd3, 0, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("zero_start", 3'b100, 8'd0, 3'd3, 0, 0, 1'b0);
    step(3'b000, 8'd0);

    // Minute clamp, then asynchronous reset in the middle of a countdown.
    step_exp("abort3", 3'b001, 8'd0, 3'd4, 0, 0, 1'b0);
    step(3'b000, 8'd0);
    step_exp("sec5", 3'b010, 8'd5, 3'd1, 0, 5, 1'b0);
    step(3'b000, 8'd0);
    step_exp("min_clamp", 3'b010, 8'd200, 3'd3, 99, 5, 1'b0);
    step(3'b000, 8'd0);
    step_exp("start_9905", 3'b100, 8'd0, 3'd2, 99, 5, 1'b0);
    repeat (3) step(3'b000, 8'd0);
    step_exp("tick_9904", 3'b000, 8'd0, 3'd2, 99, 4, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_now("async_reset", 3'd4, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk_now("reset_held", 3'd4, 0, 0, 1'b0);
    step_exp("post_reset", 3'b000, 8'd0, 3'd0, 0, 0, 1'b0);

    // Level abort held during TIMER.
    step_exp("sec5b", 3'b010, 8'd5, 3'd1, 0, 5, 1'b0);
    step(3'b000, 8'd0);
    step_exp("min1b", 3'b010, 8'd1, 3'd3, 1, 5, 1'b0);
    step(3'b000, 8'd0);
    step_exp("start_0105", 3'b100, 8'd0, 3'd2, 1, 5, 1'b0);
    repeat (2) step(3'b000, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step_exp($sformatf("abort_hold%0d", i), 3'b001, 8'd0, 3'd4, 0, 0, 1'b0);
    end
    step_exp("abort_release", 3'b000, 8'd0, 3'd0, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
